// File: rtl/teclado_pkg.sv
// Shared constants and FSM state type for the note index encoder/decoder pair.
package teclado_pkg;

    localparam int NOTES_PER_OCTAVE = 13;
    localparam int NUM_OCTAVES      = 5;
    localparam int MAX_NOTE         = NUM_OCTAVES * NOTES_PER_OCTAVE;
    localparam int IDX_W            = 8;
    localparam int OCT_W            = 3;
    localparam int NOTE_W           = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/note_octave_lut.sv
// Single-step decode of a linear note index into octave/note via a compare ladder.
// Out-of-range indices (0 or above MAX_NOTE) give err=1 with zero octave/note.
module note_octave_lut
    import teclado_pkg::*;
(
    input  logic [IDX_W-1:0]  idx,
    output logic [OCT_W-1:0]  oct,
    output logic [NOTE_W-1:0] note,
    output logic              err
);

    logic [IDX_W-1:0] base;

    always_comb begin
        oct  = '0;
        note = '0;
        err  = 1'b1;
        base = '0;
        if (idx != '0 && idx <= IDX_W'(MAX_NOTE)) begin
            err = 1'b0;
            // Walk downward so the lowest octave whose ceiling covers idx wins.
            for (int k = NUM_OCTAVES; k >= 1; k--) begin
                if (idx <= IDX_W'(k * NOTES_PER_OCTAVE))
                    oct = OCT_W'(k);
            end
            base = IDX_W'((int'(oct) - 1) * NOTES_PER_OCTAVE);
            note = NOTE_W'(idx - base);
        end
    end

endmodule

// File: rtl/note_to_teclado.sv
// Decodes a linear note index (1..65) into octave/note with valid/ready on both sides.
// Build option NOTE_TO_TECLADO_FASTPATH_EN replaces the subtract-by-13 loop with a LUT.
module note_to_teclado
    import teclado_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  nota_final,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OCT_W-1:0]  nro_octava,
    output logic [NOTE_W-1:0] nota_entrada,
    output logic              nota_error
);

    state_t            state, state_nx;
    logic [IDX_W-1:0]  rem, rem_nx;
    logic [OCT_W-1:0]  oct_o_nx;
    logic [NOTE_W-1:0] note_nx;
    logic              err_nx, ov_nx;

`ifdef NOTE_TO_TECLADO_FASTPATH_EN
    logic [OCT_W-1:0]  lut_oct;
    logic [NOTE_W-1:0] lut_note;
    logic              lut_err;

    note_octave_lut u_lut (
        .idx  (rem),
        .oct  (lut_oct),
        .note (lut_note),
        .err  (lut_err)
    );
`else
    logic [OCT_W-1:0]  oct, oct_nx;
`endif

    // in_ready follows reset release combinationally so it rises the moment rst_n does.
    assign in_ready = rst_n && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        oct_o_nx = nro_octava;
        note_nx  = nota_entrada;
        err_nx   = nota_error;
        ov_nx    = out_valid;
`ifndef NOTE_TO_TECLADO_FASTPATH_EN
        oct_nx   = oct;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    rem_nx = nota_final;
`ifdef NOTE_TO_TECLADO_FASTPATH_EN
                    state_nx = DONE;
`else
                    if (nota_final == '0 || nota_final > IDX_W'(MAX_NOTE)) begin
                        state_nx = DONE;
                    end else begin
                        oct_nx   = OCT_W'(1);
                        state_nx = DIVIDE;
                    end
`endif
                end
            end
`ifndef NOTE_TO_TECLADO_FASTPATH_EN
            DIVIDE: begin
                if (rem > IDX_W'(NOTES_PER_OCTAVE)) begin
                    rem_nx = rem - IDX_W'(NOTES_PER_OCTAVE);
                    oct_nx = oct + OCT_W'(1);
                end else begin
                    oct_o_nx = oct;
                    note_nx  = NOTE_W'(rem);
                    err_nx   = 1'b0;
                    ov_nx    = 1'b1;
                    state_nx = DONE;
                end
            end
`endif
            DONE: begin
                // Entering DONE without out_valid means the result is resolved on this edge.
                if (!out_valid) begin
`ifdef NOTE_TO_TECLADO_FASTPATH_EN
                    oct_o_nx = lut_oct;
                    note_nx  = lut_note;
                    err_nx   = lut_err;
`else
                    oct_o_nx = '0;
                    note_nx  = '0;
                    err_nx   = 1'b1;
`endif
                    ov_nx = 1'b1;
                end else if (out_ready) begin
                    ov_nx    = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem          <= '0;
            nro_octava   <= '0;
            nota_entrada <= '0;
            nota_error   <= 1'b0;
            out_valid    <= 1'b0;
`ifndef NOTE_TO_TECLADO_FASTPATH_EN
            oct          <= '0;
`endif
        end else begin
            rem          <= rem_nx;
            nro_octava   <= oct_o_nx;
            nota_entrada <= note_nx;
            nota_error   <= err_nx;
            out_valid    <= ov_nx;
`ifndef NOTE_TO_TECLADO_FASTPATH_EN
            oct          <= oct_nx;
`endif
        end
    end

endmodule

// File: tb/tb_note_to_teclado.sv
// Bench for note_to_teclado: arithmetic reference model, queue scoreboard, directed vectors.
module tb_note_to_teclado;
    import teclado_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [IDX_W-1:0]  nota_final = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [OCT_W-1:0]  nro_octava;
    logic [NOTE_W-1:0] nota_entrada;
    logic              nota_error;

    note_to_teclado dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .nota_final   (nota_final),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .nro_octava   (nro_octava),
        .nota_entrada (nota_entrada),
        .nota_error   (nota_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int oct;
        int note;
        int err;
    } res_t;

    res_t exp_q[$];
    int total = 0;
    int bad = 0;
    int n_acc = 0;
    int n_done = 0;

    function automatic res_t model(input int idx);
        res_t r;
        r.oct = 0; r.note = 0; r.err = 1;
        if (idx >= 1 && idx <= 65) begin
            r.oct  = (idx - 1) / 13 + 1;
            r.note = idx - (r.oct - 1) * 13;
            r.err  = 0;
        end
        return r;
    endfunction

    function automatic int lat(input int idx);
        res_t r;
        r = model(idx);
`ifdef NOTE_TO_TECLADO_FASTPATH_EN
        return 1;
`else
        return (r.err != 0) ? 1 : r.oct;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every cycle a result is presented it must match the oldest accepted index.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_out_valid: got oct=%0d note=%0d err=%0d with nothing pending",
                         nro_octava, nota_entrada, nota_error);
            end else begin
                chk("nro_octava", int'(nro_octava), exp_q[0].oct);
                chk("nota_entrada", int'(nota_entrada), exp_q[0].note);
                chk("nota_error", int'(nota_error), exp_q[0].err);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    n_done++;
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge where out_valid is first seen.
    task automatic send(input int idx);
        int n;
        int k;
        logic [31:0] v;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("in_ready_wait_%0d", idx), int'(in_ready), 1);
        v = idx;
        in_valid   = 1'b1;
        nota_final = v[7:0];
        exp_q.push_back(model(idx));
        n_acc++;
        @(negedge clk);
        in_valid   = 1'b0;
        nota_final = 8'($urandom);
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("latency_%0d", idx), k, lat(idx));
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 out_ready = v;
        @(negedge clk);
    endtask

    task automatic pin(input int idx, input int o, input int nt, input int e);
        res_t r;
        r = model(idx);
        chk($sformatf("model_oct_%0d", idx), r.oct, o);
        chk($sformatf("model_note_%0d", idx), r.note, nt);
        chk($sformatf("model_err_%0d", idx), r.err, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int vec_idx[7]  = '{1, 13, 14, 65, 0, 66, 255};
    int vec_oct[7]  = '{1, 1, 2, 5, 0, 0, 0};
    int vec_note[7] = '{1, 13, 1, 13, 0, 0, 0};
    int vec_err[7]  = '{0, 0, 0, 0, 1, 1, 1};

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_oct", int'(nro_octava), 0);
        chk("rst_note", int'(nota_entrada), 0);
        chk("rst_err", int'(nota_error), 0);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            pin(vec_idx[i], vec_oct[i], vec_note[i], vec_err[i]);
            send(vec_idx[i]);
        end

        // Backpressure with a rejected index offered while the result is held.
        pin(40, 4, 1, 0);
        pin(7, 1, 7, 0);
        set_ready(1'b0);
        send(40);
        for (int i = 0; i < 10; i++) begin
            in_valid   = (i % 2 == 0);
            nota_final = 8'd7;
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        set_ready(1'b1);
        send(7);

        for (int i = 1; i <= 65; i++) send(i);

        // Asynchronous reset while 60 is still being divided.
        pin(27, 3, 1, 0);
        while (!in_ready) @(negedge clk);
        in_valid   = 1'b1;
        nota_final = 8'd60;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_oct", int'(nro_octava), 0);
        chk("arst_note", int'(nota_entrada), 0);
        chk("arst_err", int'(nota_error), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("arst_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("arst_no_result", int'(out_valid), 0);
        end
        send(27);

        repeat (3) @(negedge clk);
        chk("result_count", n_done, n_acc);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
